// File: rtl/alu_sweep_ctrl.sv
// alu_sweep_ctrl: sequences one operand pair through a chosen subset of
// the four ALU opcodes in ascending order. It samples the combinational
// ALU result at the end of each issue cycle and offers every result on a
// valid/ready stream. A one-cycle done pulse closes each command.
module alu_sweep_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_mask,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_s,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [1:0] res_op,
  output logic [3:0] res_s,
  output logic       res_zero,
  output logic       done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] OUT   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] op_idx_q, op_idx_d;
  logic [3:0] res_s_q, res_s_d;
  logic [1:0] res_op_q, res_op_d;
  logic       res_zero_q, res_zero_d;
  logic       higher_set;

  // Any selected opcode above the current one still waiting to be issued?
  always_comb begin
    higher_set = 1'b0;
    case (op_idx_q)
      2'd0:    higher_set = |mask_q[3:1];
      2'd1:    higher_set = |mask_q[3:2];
      2'd2:    higher_set = mask_q[3];
      default: higher_set = 1'b0;
    endcase
  end

  // Next-state and datapath update for the sweep sequencer.
  always_comb begin
    // NOTE: every _d starts as its _q so that no path through the case
    // leaves a signal unassigned, which would infer a latch.
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    mask_d     = mask_q;
    op_idx_d   = op_idx_q;
    res_s_d    = res_s_q;
    res_op_d   = res_op_q;
    res_zero_d = res_zero_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          a_d      = cmd_a;
          b_d      = cmd_b;
          mask_d   = cmd_mask;
          op_idx_d = 2'd0;
          state_d  = (cmd_mask != 4'd0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (mask_q[op_idx_q]) begin
          res_s_d    = alu_s;
          res_op_d   = op_idx_q;
          res_zero_d = (alu_s == 4'd0);
          state_d    = OUT;
        end else if (op_idx_q == 2'd3) begin
          state_d = DONE;
        end else begin
          op_idx_d = op_idx_q + 2'd1;
        end
      end
      OUT: begin
        // The result stays put until the consumer takes it.
        if (res_ready) begin
          if (op_idx_q == 2'd3 || !higher_set) begin
            state_d = DONE;
          end else begin
            op_idx_d = op_idx_q + 2'd1;
            state_d  = ISSUE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any in-flight work.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so that all flops update from
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      mask_q     <= 4'd0;
      op_idx_q   <= 2'd0;
      res_s_q    <= 4'd0;
      res_op_q   <= 2'd0;
      res_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mask_q     <= mask_d;
      op_idx_q   <= op_idx_d;
      res_s_q    <= res_s_d;
      res_op_q   <= res_op_d;
      res_zero_q <= res_zero_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == OUT);
  assign done      = (state_q == DONE);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_idx_q;
  assign res_s     = res_s_q;
  assign res_op    = res_op_q;
  assign res_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Bench for alu_sweep_ctrl. A small combinational ALU model closes the
// loop. Directed vectors cover full, sparse and empty masks; hand-written
// sequences cover back-pressure, a held command and reset mid-result.
module tb_alu_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a, cmd_b, cmd_mask;
  logic [3:0] alu_a, alu_b, alu_s;
  logic [1:0] alu_op;
  logic       res_valid, res_ready;
  logic [1:0] res_op;
  logic [3:0] res_s;
  logic       res_zero;
  logic       done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_sweep_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_mask  (cmd_mask),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_s     (alu_s),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_op    (res_op),
    .res_s     (res_s),
    .res_zero  (res_zero),
    .done      (done)
  );

  // ALU being driven: 00 add, 01 sub, 10 and, 11 or, all mod 16.
  always_comb begin
    case (alu_op)
      2'd0:    alu_s = alu_a + alu_b;
      2'd1:    alu_s = alu_a - alu_b;
      2'd2:    alu_s = alu_a & alu_b;
      default: alu_s = alu_a | alu_b;
    endcase
  end

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  mask;
    int          n;        // expected result count
    logic [7:0]  ops;      // result i opcode at [2i+:2]
    logic [15:0] ss;       // result i value at [4i+:4]
    logic [3:0]  zs;       // result i zero flag at [i]
    int          done_cyc; // cycle of done, counted from acceptance edge
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Entered and left at a negedge. Presents one command with res_ready=1,
  // collects results and the done cycle, then compares to the vector.
  task automatic run_vec(input vec_t v, input string tag);
    logic [1:0] got_op[4];
    logic [3:0] got_s[4];
    logic       got_z[4];
    int nres = 0;
    int done_cyc = -1;
    int busy_ready = 0;
    int waited = 0;
    res_ready = 1'b1;
    cmd_a = v.a; cmd_b = v.b; cmd_mask = v.mask; cmd_valid = 1'b1;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " accept"}, int'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cmd_ready) busy_ready++;
      if (res_valid) begin
        if (nres < 4) begin
          got_op[nres] = res_op;
          got_s[nres]  = res_s;
          got_z[nres]  = res_zero;
        end
        nres++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    check({tag, " done_cycle"}, done_cyc, v.done_cyc);
    check({tag, " result_count"}, nres, v.n);
    check({tag, " cmd_ready_busy"}, busy_ready, 0);
    for (int i = 0; i < v.n && i < nres; i++) begin
      check($sformatf("%s res%0d_op", tag, i), int'(got_op[i]), int'(v.ops[2*i +: 2]));
      check($sformatf("%s res%0d_s", tag, i), int'(got_s[i]), int'(v.ss[4*i +: 4]));
      check($sformatf("%s res%0d_zero", tag, i), int'(got_z[i]), int'(v.zs[i]));
    end
    @(negedge clk);
    check({tag, " ready_after_done"}, int'(cmd_ready), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cmd_ready"}, int'(cmd_ready), 1);
    check({tag, " alu_a"}, int'(alu_a), 0);
    check({tag, " alu_b"}, int'(alu_b), 0);
    check({tag, " alu_op"}, int'(alu_op), 0);
    check({tag, " res_valid"}, int'(res_valid), 0);
    check({tag, " res_op"}, int'(res_op), 0);
    check({tag, " res_s"}, int'(res_s), 0);
    check({tag, " res_zero"}, int'(res_zero), 0);
    check({tag, " done"}, int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int dcyc;
    int busy;
    logic [3:0] last_s;
    logic [15:0] seq_s;

    vecs[0] = '{a: 4'hA, b: 4'h2, mask: 4'hF, n: 4, ops: 8'hE4, ss: 16'hA28C, zs: 4'h0, done_cyc: 9};
    vecs[1] = '{a: 4'h5, b: 4'h5, mask: 4'h2, n: 1, ops: 8'h01, ss: 16'h0000, zs: 4'h1, done_cyc: 4};
    vecs[2] = '{a: 4'h9, b: 4'h6, mask: 4'h0, n: 0, ops: 8'h00, ss: 16'h0000, zs: 4'h0, done_cyc: 1};
    vecs[3] = '{a: 4'h3, b: 4'h4, mask: 4'h8, n: 1, ops: 8'h03, ss: 16'h0007, zs: 4'h0, done_cyc: 6};
    vecs[4] = '{a: 4'hF, b: 4'h1, mask: 4'h5, n: 2, ops: 8'h08, ss: 16'h0010, zs: 4'h1, done_cyc: 6};
    vecs[5] = '{a: 4'h2, b: 4'h7, mask: 4'h6, n: 2, ops: 8'h09, ss: 16'h002B, zs: 4'h0, done_cyc: 6};

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_mask = '0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: first result held for 5 cycles with res_ready low.
    res_ready = 1'b0;
    cmd_a = 4'hA; cmd_b = 4'h2; cmd_mask = 4'hF; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("bp issue_no_valid", int'(res_valid), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d valid", i), int'(res_valid), 1);
      check($sformatf("bp hold%0d s", i), int'(res_s), 12);
      check($sformatf("bp hold%0d op", i), int'(res_op), 0);
      check($sformatf("bp hold%0d alu_op", i), int'(alu_op), 0);
    end
    res_ready = 1'b1;
    cnt = 0; dcyc = -1; last_s = '0;
    for (int cyc = 7; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (res_valid) begin
        cnt++;
        last_s = res_s;
      end
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    check("bp done_cycle", dcyc, 13);
    check("bp remaining_results", cnt, 3);
    check("bp last_s", int'(last_s), 10);
    @(negedge clk);

    // Held cmd_valid: second command changes during the first sweep.
    cmd_a = 4'hA; cmd_b = 4'h2; cmd_mask = 4'hF; cmd_valid = 1'b1;
    @(posedge clk);
    #1 begin cmd_a = 4'h3; cmd_b = 4'h4; cmd_mask = 4'h1; end
    cnt = 0; dcyc = -1; busy = 0; seq_s = '0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cmd_ready) busy++;
      if (res_valid) begin
        if (cnt < 4) seq_s[4*cnt +: 4] = res_s;
        cnt++;
      end
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    check("hold done_cycle", dcyc, 9);
    check("hold first_results", int'(seq_s), 16'hA28C);
    check("hold first_count", cnt, 4);
    check("hold not_accepted_early", busy, 0);
    @(negedge clk);
    check("hold ready_idle", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("hold second_issue", int'(res_valid), 0);
    @(negedge clk);
    check("hold second_valid", int'(res_valid), 1);
    check("hold second_s", int'(res_s), 7);
    check("hold second_alu_a", int'(alu_a), 3);
    check("hold second_alu_b", int'(alu_b), 4);
    @(negedge clk);
    check("hold second_done", int'(done), 1);
    @(negedge clk);

    // Reset while a result is pending in OUT.
    res_ready = 1'b0;
    cmd_a = 4'hA; cmd_b = 4'h2; cmd_mask = 4'hF; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out pre_valid", int'(res_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_out");
    rst = 1'b0;
    run_vec(vecs[0], "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
